// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 keyboard receiver: FSM state encoding and
// the scan codes the receiver and the downstream field counters care about.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    PAR  = 2'd2,
    STOP = 2'd3
  } ps2_state_t;

  localparam logic [7:0] BRK_CODE = 8'hF0;
  localparam logic [7:0] EXT_CODE = 8'hE0;
  localparam logic [7:0] KEY_UP   = 8'h75;
  localparam logic [7:0] KEY_DN   = 8'h72;

  localparam int unsigned WD_W = 16;

endpackage

// File: rtl/ps2_filtro.sv
// PS/2 line conditioning: 2-FF synchronisers on clock and data, plus a
// FILT-sample glitch filter on the clock that yields a one-cycle fall strobe.
module ps2_filtro #(
  parameter int unsigned FILT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic i_ps2_clk,
  input  logic i_ps2_data,
  output logic o_clk_f,
  output logic o_fall,
  output logic o_data_s
);

  localparam int unsigned CW = (FILT > 1) ? $clog2(FILT) : 1;

  logic [1:0]    r_clk_sync;
  logic [1:0]    r_data_sync;
  logic [CW-1:0] r_cnt;
  logic          r_clk_f;
  logic          r_fall;

  // Synchronisers idle high like the PS/2 lines; the filter flips clk_f only
  // after FILT consecutive samples disagree with it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_clk_sync  <= 2'b11;
      r_data_sync <= 2'b11;
      r_cnt       <= '0;
      r_clk_f     <= 1'b1;
      r_fall      <= 1'b0;
    end else begin
      r_clk_sync  <= {r_clk_sync[0], i_ps2_clk};
      r_data_sync <= {r_data_sync[0], i_ps2_data};
      r_fall      <= 1'b0;
      if (r_clk_sync[1] == r_clk_f) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(FILT - 1)) begin
        r_cnt   <= '0;
        r_clk_f <= r_clk_sync[1];
        r_fall  <= r_clk_f;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_clk_f  = r_clk_f;
  assign o_fall   = r_fall;
  assign o_data_s = r_data_sync[1];

endmodule

// File: rtl/ps2_rx_teclado.sv
// PS/2 keyboard receiver: frames scan codes, drops break sequences and emits
// make codes to the date/time field counters. Option macro: EXT_CODE_EN.
module ps2_rx_teclado
  import ps2_pkg::*;
#(
  parameter int unsigned N       = 8,
  parameter int unsigned FILT    = 8,
  parameter logic [15:0] TIMEOUT = 16'd50000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ps2_clk,
  input  logic         ps2_data,
  output logic [N-1:0] key_code,
  output logic         en_codigo,
`ifdef EXT_CODE_EN
  output logic         key_ext,
`endif
  output logic         err_paridad
);

  localparam int unsigned BW = (N > 1) ? $clog2(N) : 1;

  logic w_clk_f;
  logic w_fall;
  logic w_data_s;

  ps2_filtro #(
    .FILT(FILT)
  ) u_filtro (
    .clk       (clk),
    .rst       (rst),
    .i_ps2_clk (ps2_clk),
    .i_ps2_data(ps2_data),
    .o_clk_f   (w_clk_f),
    .o_fall    (w_fall),
    .o_data_s  (w_data_s)
  );

  ps2_state_t      r_state;
  ps2_state_t      w_state_nxt;
  logic [N-1:0]    r_sh;
  logic [BW-1:0]   r_bit;
  logic            r_par;
  logic [WD_W-1:0] r_wd;
  logic            r_brk;
  logic [N-1:0]    r_key_code;
  logic            r_en;
  logic            r_err;
`ifdef EXT_CODE_EN
  logic            r_ext;
  logic            r_key_ext;
`endif

  logic w_timeout;
  logic w_shift;
  logic w_cap_par;
  logic w_stop;
  logic w_ok;

  // Watchdog expiry; a fall in the same cycle keeps the frame alive.
  assign w_timeout = (r_state != IDLE) && !w_fall && (r_wd == (TIMEOUT - 16'd1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: if (w_fall && !w_clk_f && !w_data_s) w_state_nxt = DATA;
      DATA: if (w_fall && (r_bit == BW'(N - 1))) w_state_nxt = PAR;
      PAR:  if (w_fall) w_state_nxt = STOP;
      STOP: if (w_fall) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
    if (w_timeout) w_state_nxt = IDLE;
  end

  always_comb begin
    w_shift   = 1'b0;
    w_cap_par = 1'b0;
    w_stop    = 1'b0;
    case (r_state)
      DATA:    w_shift   = w_fall;
      PAR:     w_cap_par = w_fall;
      STOP:    w_stop    = w_fall;
      default: ;
    endcase
    w_ok = w_data_s & (^{r_sh, r_par});
  end

  // Datapath: shift register, watchdog, break/extended flags and the
  // registered code/pulse outputs, all updated on the stop-bit fall.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sh       <= '0;
      r_bit      <= '0;
      r_par      <= 1'b0;
      r_wd       <= '0;
      r_brk      <= 1'b0;
      r_key_code <= '0;
      r_en       <= 1'b0;
      r_err      <= 1'b0;
`ifdef EXT_CODE_EN
      r_ext      <= 1'b0;
      r_key_ext  <= 1'b0;
`endif
    end else begin
      r_en  <= 1'b0;
      r_err <= 1'b0;

      if ((r_state == IDLE) || w_fall || w_timeout) r_wd <= '0;
      else                                           r_wd <= r_wd + 16'd1;

      if (r_state == IDLE) r_bit <= '0;
      if (w_shift) begin
        r_sh  <= {w_data_s, r_sh[N-1:1]};
        r_bit <= r_bit + BW'(1);
      end
      if (w_cap_par) r_par <= w_data_s;

      if (w_stop) begin
        if (!w_ok) begin
          r_err <= 1'b1;
        end else if (r_sh == N'(BRK_CODE)) begin
          r_brk <= 1'b1;
        end else if (r_sh == N'(EXT_CODE)) begin
`ifdef EXT_CODE_EN
          r_ext <= 1'b1;
`endif
        end else if (r_brk) begin
          r_brk <= 1'b0;
`ifdef EXT_CODE_EN
          r_ext <= 1'b0;
`endif
        end else begin
          r_key_code <= r_sh;
          r_en       <= 1'b1;
`ifdef EXT_CODE_EN
          r_key_ext  <= r_ext;
          r_ext      <= 1'b0;
`endif
        end
      end
    end
  end

  assign key_code    = r_key_code;
  assign en_codigo   = r_en;
  assign err_paridad = r_err;
`ifdef EXT_CODE_EN
  assign key_ext     = r_key_ext;
`endif

endmodule

// File: tb/tb_ps2_rx_teclado.sv
// Self-checking bench for ps2_rx_teclado: directed scenarios plus a randomized
// frame stream compared against a scan-code level reference model.
module tb_ps2_rx_teclado;

  localparam int unsigned FILT = 8;
  localparam int unsigned HALF = 30;
  localparam logic [15:0] TMO  = 16'd300;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] key_code;
  logic       en_codigo;
  logic       err_paridad;
`ifdef EXT_CODE_EN
  logic       key_ext;
`endif

  always #5 clk = ~clk;

  ps2_rx_teclado #(
    .N(8),
    .FILT(FILT),
    .TIMEOUT(TMO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .key_code   (key_code),
    .en_codigo  (en_codigo),
`ifdef EXT_CODE_EN
    .key_ext    (key_ext),
`endif
    .err_paridad(err_paridad)
  );

  int errors = 0;
  int checks = 0;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: pulse counts, captured code and overlap count.
  int         n_en = 0;
  int         n_err = 0;
  int         n_both = 0;
  int         en_cyc = 0;
  logic       last_ext = 1'b0;
  always @(negedge clk) begin
    if (en_codigo) begin
      n_en   <= n_en + 1;
      en_cyc <= cyc;
`ifdef EXT_CODE_EN
      last_ext <= key_ext;
`endif
    end
    if (err_paridad) n_err <= n_err + 1;
    if (en_codigo && err_paridad) n_both <= n_both + 1;
  end

  // Reference model at scan-code level.
  logic       m_brk = 1'b0;
  logic       m_ext = 1'b0;
  logic [7:0] m_code = 8'h00;
  logic       m_kext = 1'b0;
  int         e_en;
  int         e_err;
  int         stop_cyc = 0;

  task automatic model_frame(input logic [7:0] b, input bit flip);
    e_en  = 0;
    e_err = 0;
    if (flip) e_err = 1;
    else if (b == 8'hF0) m_brk = 1'b1;
    else if (b == 8'hE0) begin
`ifdef EXT_CODE_EN
      m_ext = 1'b1;
`endif
    end else if (m_brk) begin
      m_brk = 1'b0;
      m_ext = 1'b0;
    end else begin
      e_en   = 1;
      m_code = b;
      m_kext = m_ext;
      m_ext  = 1'b0;
    end
  endtask

  task automatic model_reset();
    m_brk = 1'b0; m_ext = 1'b0; m_code = 8'h00; m_kext = 1'b0;
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One PS/2 bit: data set while clock high, then a low phase; optional
  // short glitches placed after the filtered level has settled.
  task automatic ps2_bit(input logic b, input bit glitch);
    ps2_data = b;
    wait_clk(12);
    if (glitch) begin ps2_clk = 1'b0; wait_clk(3); ps2_clk = 1'b1; end
    else wait_clk(3);
    wait_clk(HALF - 15);
    ps2_clk  = 1'b0;
    stop_cyc = cyc;
    wait_clk(15);
    if (glitch) begin ps2_clk = 1'b1; wait_clk(3); ps2_clk = 1'b0; end
    else wait_clk(3);
    wait_clk(HALF - 18);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit flip, input bit glitch);
    logic p;
    p = ~(^b) ^ flip;
    model_frame(b, flip);
    ps2_bit(1'b0, glitch);
    for (int i = 0; i < 8; i++) ps2_bit(b[i], glitch);
    ps2_bit(p, glitch);
    ps2_bit(1'b1, glitch);
    wait_clk(20);
  endtask

  task automatic send_partial(input logic [7:0] b, input int nbits);
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < nbits; i++) ps2_bit(b[i], 1'b0);
  endtask

  task automatic test_reset();
    wait_clk(5);
    checks++;
    if (key_code !== 8'h00 || en_codigo !== 1'b0 || err_paridad !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: code=%h en=%b err=%b required 00/0/0", key_code, en_codigo, err_paridad);
    end
    rst = 1'b1;
    wait_clk(10);
    checks++;
    if (key_code !== 8'h00 || n_en !== 0 || n_err !== 0) begin
      errors++;
      $display("FAIL reset_idle: code=%h pulses=%0d errs=%0d required 00/0/0", key_code, n_en, n_err);
    end
  endtask

  task automatic test_make();
    int n0, r0, lat;
    n0 = n_en; r0 = n_err;
    send_frame(8'h75, 1'b0, 1'b0);
    lat = en_cyc - stop_cyc;
    checks++;
    if (n_en - n0 !== 1 || n_err - r0 !== 0) begin
      errors++;
      $display("FAIL make_pulses: en=%0d err=%0d required 1/0", n_en - n0, n_err - r0);
    end
    checks++;
    if (key_code !== 8'h75) begin
      errors++;
      $display("FAIL make_code: got %h required 75", key_code);
    end
    checks++;
    if (lat < int'(FILT) + 2 || lat > int'(FILT) + 5) begin
      errors++;
      $display("FAIL make_latency: got %0d cycles required %0d..%0d", lat, FILT + 2, FILT + 5);
    end
  endtask

  task automatic test_break();
    int n0;
    n0 = n_en;
    send_frame(8'h75, 1'b0, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'h75, 1'b0, 1'b0);
    checks++;
    if (n_en - n0 !== 1 || key_code !== 8'h75) begin
      errors++;
      $display("FAIL break_seq: pulses=%0d code=%h required 1/75", n_en - n0, key_code);
    end
    n0 = n_en;
    send_frame(8'h72, 1'b0, 1'b0);
    checks++;
    if (n_en - n0 !== 1 || key_code !== 8'h72) begin
      errors++;
      $display("FAIL break_cleared: pulses=%0d code=%h required 1/72", n_en - n0, key_code);
    end
  endtask

  task automatic test_parity();
    int n0, r0;
    send_frame(8'h75, 1'b0, 1'b0);
    n0 = n_en; r0 = n_err;
    send_frame(8'h72, 1'b1, 1'b0);
    checks++;
    if (n_err - r0 !== 1 || n_en - n0 !== 0) begin
      errors++;
      $display("FAIL parity_pulses: err=%0d en=%0d required 1/0", n_err - r0, n_en - n0);
    end
    checks++;
    if (key_code !== 8'h75) begin
      errors++;
      $display("FAIL parity_code: got %h required 75", key_code);
    end
  endtask

  task automatic test_timeout();
    int n0, r0;
    n0 = n_en; r0 = n_err;
    send_partial(8'h75, 4);
    wait_clk(int'(TMO) + 100);
    send_frame(8'h72, 1'b0, 1'b0);
    checks++;
    if (n_en - n0 !== 1 || n_err - r0 !== 0 || key_code !== 8'h72) begin
      errors++;
      $display("FAIL timeout: pulses=%0d errs=%0d code=%h required 1/0/72", n_en - n0, n_err - r0, key_code);
    end
  endtask

  task automatic test_async_reset();
    int n0;
    send_partial(8'h75, 6);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checks++;
    if (key_code !== 8'h00 || en_codigo !== 1'b0 || err_paridad !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: code=%h en=%b err=%b required 00/0/0", key_code, en_codigo, err_paridad);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    wait_clk(50);
    n0 = n_en;
    send_frame(8'h75, 1'b0, 1'b0);
    checks++;
    if (n_en - n0 !== 1 || key_code !== 8'h75) begin
      errors++;
      $display("FAIL after_reset: pulses=%0d code=%h required 1/75", n_en - n0, key_code);
    end
  endtask

  task automatic test_glitch();
    int n0, r0;
    n0 = n_en; r0 = n_err;
    send_frame(8'h72, 1'b0, 1'b1);
    checks++;
    if (n_en - n0 !== 1 || key_code !== 8'h72) begin
      errors++;
      $display("FAIL glitch_72: pulses=%0d code=%h required 1/72", n_en - n0, key_code);
    end
    send_frame(8'h75, 1'b0, 1'b1);
    checks++;
    if (n_en - n0 !== 2 || n_err - r0 !== 0 || key_code !== 8'h75) begin
      errors++;
      $display("FAIL glitch_75: pulses=%0d errs=%0d code=%h required 2/0/75", n_en - n0, n_err - r0, key_code);
    end
  endtask

  task automatic test_ext();
    int n0;
    n0 = n_en;
    send_frame(8'hE0, 1'b0, 1'b0);
    send_frame(8'h72, 1'b0, 1'b0);
    checks++;
    if (n_en - n0 !== 1 || key_code !== 8'h72) begin
      errors++;
      $display("FAIL ext_prefix: pulses=%0d code=%h required 1/72", n_en - n0, key_code);
    end
`ifdef EXT_CODE_EN
    checks++;
    if (last_ext !== 1'b1) begin
      errors++;
      $display("FAIL ext_flag: got %b required 1", last_ext);
    end
    send_frame(8'h75, 1'b0, 1'b0);
    checks++;
    if (last_ext !== 1'b0 || key_code !== 8'h75) begin
      errors++;
      $display("FAIL ext_cleared: ext=%b code=%h required 0/75", last_ext, key_code);
    end
`endif
  endtask

  task automatic test_random();
    int n0, r0;
    logic [7:0] b;
    bit flip, glitch;
    for (int k = 0; k < 24; k++) begin
      case ($urandom % 5)
        0: b = 8'h75;
        1: b = 8'h72;
        2: b = 8'hF0;
        3: b = 8'hE0;
        default: b = 8'($urandom);
      endcase
      flip   = ($urandom % 6) == 0;
      glitch = ($urandom % 3) == 0;
      n0 = n_en; r0 = n_err;
      send_frame(b, flip, glitch);
      checks++;
      if (n_en - n0 !== e_en || n_err - r0 !== e_err || key_code !== m_code) begin
        errors++;
        $display("FAIL rand_%0d byte=%h flip=%0d: en=%0d err=%0d code=%h required %0d/%0d/%h",
                 k, b, flip, n_en - n0, n_err - r0, key_code, e_en, e_err, m_code);
      end
`ifdef EXT_CODE_EN
      if (e_en == 1) begin
        checks++;
        if (last_ext !== m_kext) begin
          errors++;
          $display("FAIL rand_ext_%0d: got %b required %b", k, last_ext, m_kext);
        end
      end
`endif
    end
    checks++;
    if (n_both !== 0) begin
      errors++;
      $display("FAIL pulse_overlap: got %0d cycles required 0", n_both);
    end
  endtask

  initial begin
    test_reset();
    test_make();
    test_break();
    test_parity();
    test_timeout();
    test_async_reset();
    test_glitch();
    test_ext();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
